// File: rtl/fixed_round_scheduler_if.sv
// rtl/fixed_round_scheduler_if.sv - requester, rounder and result signals of the shared rounder scheduler
interface fixed_round_scheduler_if #(
   parameter int NREQ     = 4,
   parameter int IWIDTH   = 16,
   parameter int OWIDTH   = 10,
   parameter int PIPELINE = 2
);
   localparam int CW  = $clog2(NREQ);
   localparam int IFW = $clog2(PIPELINE + 1);

   logic [NREQ-1:0]        i_valid;
   logic [NREQ-1:0]        i_ready;
   logic [NREQ*IWIDTH-1:0] i_data;
   logic                   rnd_clkena;
   logic [IWIDTH-1:0]      rnd_data;
   logic [OWIDTH-1:0]      rnd_result;
   logic                   o_valid;
   logic                   o_ready;
   logic [OWIDTH-1:0]      o_data;
   logic [CW-1:0]          o_chan;
   logic [IFW-1:0]         o_inflight;

   modport master (
      output i_valid, i_data, rnd_result, o_ready,
      input  i_ready, rnd_clkena, rnd_data, o_valid, o_data, o_chan, o_inflight
   );

   modport slave (
      input  i_valid, i_data, rnd_result, o_ready,
      output i_ready, rnd_clkena, rnd_data, o_valid, o_data, o_chan, o_inflight
   );
endinterface

// File: rtl/fixed_round_scheduler.sv
// rtl/fixed_round_scheduler.sv - round-robin sharing of one pipelined rounder with a channel tag pipeline
module fixed_round_scheduler #(
   parameter int    NREQ     = 4,
   parameter int    IWIDTH   = 16,
   parameter int    OWIDTH   = 10,
   parameter string SIGNREP  = "SIGNED",
   parameter int    PIPELINE = 2
) (
   input logic clk,
   input logic rst,
   fixed_round_scheduler_if.slave bus
);
   localparam int CW  = $clog2(NREQ);
   localparam int IFW = $clog2(PIPELINE + 1);

   if (NREQ < 2 || NREQ > 16 || PIPELINE < 1 || PIPELINE > 8 || OWIDTH > IWIDTH ||
       (SIGNREP != "SIGNED" && SIGNREP != "UNSIGNED")) begin : g_bad_cfg
      $error("fixed_round_scheduler: unsupported parameter set");
   end

   logic                         adv;
   logic                         accept;
   logic                         gnt_found;
   logic [CW-1:0]                gnt_idx;
   logic [CW:0]                  cand;
   logic [CW-1:0]                ptr;
   logic [CW-1:0]                ptr_nxt;
   logic [NREQ-1:0]              ready_vec;
   logic [PIPELINE-1:0]          vld;
   logic [PIPELINE-1:0][CW-1:0]  chan;
   logic [IFW-1:0]               inflight;

   // The whole pipeline, including the external rounder, moves only when the output slot frees up.
   assign adv    = ~bus.o_valid | bus.o_ready;
   assign accept = adv & gnt_found;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr} + (CW+1)'(i);
         if (cand >= (CW+1)'(NREQ)) begin
            cand = cand - (CW+1)'(NREQ);
         end
         if (!gnt_found && bus.i_valid[cand[CW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[CW-1:0];
         end
      end
   end

   always_comb begin
      ready_vec = '0;
      if (accept) begin
         ready_vec[gnt_idx] = 1'b1;
      end
   end

   assign ptr_nxt = (gnt_idx == CW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      inflight = '0;
      for (int j = 0; j < PIPELINE; j++) begin
         inflight = inflight + IFW'(vld[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= '0;
         vld  <= '0;
         chan <= '0;
      end else begin
         if (accept) begin
            ptr <= ptr_nxt;
         end
         if (adv) begin
            vld[0]  <= accept;
            chan[0] <= gnt_idx;
            for (int j = 1; j < PIPELINE; j++) begin
               vld[j]  <= vld[j-1];
               chan[j] <= chan[j-1];
            end
         end
      end
   end

   // Idle slots feed zeros so the rounder sees a defined value for every bubble.
   assign bus.rnd_data   = gnt_found ? bus.i_data[gnt_idx*IWIDTH +: IWIDTH] : '0;
   assign bus.rnd_clkena = adv;
   assign bus.i_ready    = ready_vec;
   assign bus.o_valid    = vld[PIPELINE-1];
   assign bus.o_chan     = chan[PIPELINE-1];
   assign bus.o_data     = bus.rnd_result;
   assign bus.o_inflight = inflight;
endmodule

// File: tb/tb_fixed_round_scheduler.sv
// tb/tb_fixed_round_scheduler.sv - scoreboard bench for fixed_round_scheduler with a behavioural rounder
module tb_fixed_round_scheduler #(
   parameter int PIPE = 2
);
   localparam int NREQ = 4;
   localparam int IW   = 16;
   localparam int OW   = 10;
   localparam int CW   = $clog2(NREQ);

   typedef struct {
      int            chan;
      logic [OW-1:0] data;
      int            stamp;
   } sb_t;

   typedef struct {
      int            chan;
      logic [OW-1:0] data;
      int            cyc;
   } log_t;

   logic clk;
   logic rst;

   fixed_round_scheduler_if #(.NREQ(NREQ), .IWIDTH(IW), .OWIDTH(OW), .PIPELINE(PIPE)) bus ();

   fixed_round_scheduler #(
      .NREQ(NREQ), .IWIDTH(IW), .OWIDTH(OW), .SIGNREP("SIGNED"), .PIPELINE(PIPE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int            tests_run = 0;
   int            tests_failed = 0;
   sb_t           sb_q [$];
   log_t          log_q [$];
   logic [IW-1:0] src_q [NREQ][$];
   logic [NREQ-1:0] acc_mask = '0;
   logic [NREQ-1:0] vbits = '0;
   logic [NREQ*IW-1:0] dbits = '0;
   int            acc_cnt [NREQ];
   int            valid_pct = 100;
   int            rdy_pct = 100;
   int            adv_cnt = 0;
   int            cyc_cnt = 0;
   logic [OW-1:0] rpipe [PIPE];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   // Signed round-to-nearest, ties away from zero, saturating to OW bits.
   function automatic logic [OW-1:0] round_ref(input logic [IW-1:0] x);
      int v, a, m, r;
      v = $signed(x);
      a = (v < 0) ? -v : v;
      m = (a + (1 << (IW-OW-1))) >>> (IW-OW);
      r = (v < 0) ? -m : m;
      if (r > (1 << (OW-1)) - 1) r = (1 << (OW-1)) - 1;
      if (r < -(1 << (OW-1))) r = -(1 << (OW-1));
      return r[OW-1:0];
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (bus.rnd_clkena) begin
         rpipe[0] <= round_ref(bus.rnd_data);
         for (int j = 1; j < PIPE; j++) rpipe[j] <= rpipe[j-1];
      end
   end
   assign bus.rnd_result = rpipe[PIPE-1];

   always @(posedge clk) begin
      logic popped;
      #1;
      for (int k = 0; k < NREQ; k++) begin
         popped = 1'b0;
         if (acc_mask[k] && src_q[k].size() > 0) begin
            void'(src_q[k].pop_front());
            popped = 1'b1;
         end
         if (src_q[k].size() == 0) vbits[k] = 1'b0;
         else if (!(vbits[k] && !popped)) vbits[k] = ($urandom_range(99) < valid_pct);
         dbits[k*IW +: IW] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
      end
      acc_mask = '0;
      bus.i_valid = vbits;
      bus.i_data  = dbits;
      bus.o_ready = ($urandom_range(99) < rdy_pct);
   end

   always @(negedge clk) begin
      logic adv_m;
      sb_t  e;
      cyc_cnt++;
      if (rst) begin
         sb_q.delete();
         acc_mask = '0;
      end else begin
         adv_m = !bus.o_valid || bus.o_ready;
         check("clkena", bus.rnd_clkena, adv_m);
         check("ready_onehot", $countones(bus.i_ready) <= 1, 1);
         check("ready_only_valid", bus.i_ready & ~bus.i_valid, 0);
         acc_mask = bus.i_valid & bus.i_ready;
         for (int k = 0; k < NREQ; k++) begin
            if (acc_mask[k]) begin
               sb_q.push_back('{chan: k, data: round_ref(bus.i_data[k*IW +: IW]), stamp: adv_cnt});
               acc_cnt[k]++;
            end
         end
         if (bus.o_valid && bus.o_ready) begin
            if (sb_q.size() == 0) begin
               check("spurious_output", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("out_chan", bus.o_chan, e.chan);
               check("out_data", bus.o_data, e.data);
               check("latency", adv_cnt - e.stamp, PIPE);
            end
            log_q.push_back('{chan: int'(bus.o_chan), data: bus.o_data, cyc: cyc_cnt});
         end
         if (adv_m) adv_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input string tag, input int budget);
      int t;
      t = 0;
      while (t < budget && (sb_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
                            src_q[2].size() != 0 || src_q[3].size() != 0)) begin
         tick();
         t++;
      end
      check(tag, t < budget, 1);
   endtask

   task automatic wait_ovalid(input string tag);
      int t;
      t = 0;
      while (t < 50 && !bus.o_valid) begin
         tick();
         t++;
      end
      check(tag, bus.o_valid, 1);
   endtask

   initial begin
      int base;
      logic [IW-1:0] d0;
      logic [IW-1:0] t2_data [2] = '{16'h7FE0, 16'hFFE0};
      logic [OW-1:0] t2_exp [4] = '{10'h1FF, 10'h1FF, 10'h3FF, 10'h3FF};
      int t2_chan [4] = '{1, 3, 1, 3};
      int t4_infl;

      for (int k = 0; k < NREQ; k++) acc_cnt[k] = 0;
      rst = 1'b1;
      bus.i_valid = '0;
      bus.i_data  = '0;
      bus.o_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_o_chan", bus.o_chan, 0);
      check("rst_inflight", bus.o_inflight, 0);
      check("rst_clkena", bus.rnd_clkena, 1);
      check("rst_i_ready", bus.i_ready, 0);

      // single sample from requester 0
      base = log_q.size();
      src_q[0].push_back(16'h0020);
      drain("t1_drain", 50);
      check("t1_count", log_q.size() - base, 1);
      if (log_q.size() > base) begin
         check("t1_data", log_q[base].data, 10'h001);
         check("t1_chan", log_q[base].chan, 0);
      end
      tick();
      check("t1_inflight", bus.o_inflight, 0);

      // requesters 1 and 3 interleave, one result per cycle
      base = log_q.size();
      for (int i = 0; i < 2; i++) begin
         src_q[1].push_back(t2_data[i]);
         src_q[3].push_back(t2_data[i]);
      end
      drain("t2_drain", 50);
      check("t2_count", log_q.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < log_q.size()) begin
            check("t2_chan", log_q[base+i].chan, t2_chan[i]);
            check("t2_data", log_q[base+i].data, t2_exp[i]);
            if (i > 0) check("t2_back_to_back", log_q[base+i].cyc - log_q[base+i-1].cyc, 1);
         end
      end

      // all four continuously valid: strict rotation
      base = log_q.size();
      for (int k = 0; k < NREQ; k++) begin
         acc_cnt[k] = 0;
         for (int n = 0; n < 4; n++) src_q[k].push_back(IW'($urandom));
      end
      drain("t3_drain", 100);
      for (int k = 0; k < NREQ; k++) check("t3_accepts", acc_cnt[k], 4);
      check("t3_count", log_q.size() - base, 16);
      for (int i = 0; i < 16; i++) begin
         if (base + i < log_q.size()) check("t3_order", log_q[base+i].chan, i % NREQ);
      end

      // output stall with a full pipeline
      rdy_pct = 0;
      tick();
      base = log_q.size();
      d0 = 16'h1234;
      src_q[0].push_back(d0);
      src_q[1].push_back(16'h8000);
      src_q[2].push_back(16'h0041);
      wait_ovalid("t4_fill");
      t4_infl = (PIPE < 3) ? PIPE : 3;
      for (int c = 0; c < 5; c++) begin
         check("t4_clkena", bus.rnd_clkena, 0);
         check("t4_i_ready", bus.i_ready, 0);
         check("t4_o_valid", bus.o_valid, 1);
         check("t4_o_data", bus.o_data, round_ref(d0));
         check("t4_o_chan", bus.o_chan, 0);
         check("t4_inflight", bus.o_inflight, t4_infl);
         tick();
      end
      rdy_pct = 100;
      drain("t4_drain", 50);
      check("t4_count", log_q.size() - base, 3);
      for (int i = 0; i < 3; i++) begin
         if (base + i < log_q.size()) check("t4_chan", log_q[base+i].chan, i);
      end
      if (base + 1 < log_q.size()) check("t4_consecutive", log_q[base+1].cyc - log_q[base].cyc, 1);

      // reset with samples in flight; pointer returns to 0
      rdy_pct = 0;
      tick();
      base = log_q.size();
      src_q[0].push_back(16'h0100);
      src_q[1].push_back(16'h0200);
      wait_ovalid("t5_fill");
      tick();
      check("t5_inflight_pre", bus.o_inflight, (PIPE < 2) ? PIPE : 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_o_valid", bus.o_valid, 0);
      check("t5_inflight", bus.o_inflight, 0);
      check("t5_discarded", log_q.size() - base, 0);
      rdy_pct = 100;
      src_q[2].push_back(16'h0300);
      src_q[0].push_back(16'h0400);
      drain("t5_drain", 50);
      check("t5_count", log_q.size() - base, 2);
      if (base + 1 < log_q.size()) begin
         check("t5_first", log_q[base].chan, 0);
         check("t5_second", log_q[base+1].chan, 2);
      end

      // random valid/ready traffic
      valid_pct = 50;
      rdy_pct = 50;
      base = log_q.size();
      for (int n = 0; n < 200; n++) src_q[$urandom_range(NREQ-1)].push_back(IW'($urandom));
      drain("t6_drain", 20000);
      check("t6_count", log_q.size() - base, 200);
      tick();
      check("t6_inflight", bus.o_inflight, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed + 1);
      $fatal(1);
   end
endmodule
